// File: rtl/spi_adc_pkg.sv
// Shared types and defaults for the SPI ADC reader: FSM state encoding, default
// timing parameters and the serial clock idle level.
package spi_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL,
        ST_GAP
    } state_t;

    localparam int DEF_CLK_DIV     = 5;
    localparam int DEF_SAMPLE_BITS = 16;

    localparam logic SCLK_IDLE = 1'b1;

endpackage

// File: rtl/spi_adc_master_tick.sv
// Half-period counter: counts 0..CLK_DIV-1 while enabled, ticks on the last count.
// Zero latency from count to tick; clr parks the count at 0 (no backpressure).
module spi_tick_gen
    import spi_adc_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic phase_start
);

    localparam logic [3:0] LAST = 4'(CLK_DIV - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign tick        = !clr && (cnt_q == LAST);
    assign phase_start = (cnt_q == 4'd0);

    always_comb begin
        cnt_d = cnt_q + 4'd1;
        if (clr || tick) begin
            cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_adc_master.sv
// SPI ADC frame reader: nCS/SCLK sequencing, MSB-first capture, one-cycle sample strobe.
// Frame latency (2N+2)*D+1 cycles from start to strobe; start ignored while busy.
module spi_adc_master
    import spi_adc_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int SAMPLE_BITS = DEF_SAMPLE_BITS
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   MISO,
    output logic                   nCS,
    output logic                   SCLK,
    output logic                   busy,
    output logic [SAMPLE_BITS-1:0] sample,
    output logic                   sample_valid
);

    localparam int BCW = $clog2(SAMPLE_BITS + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(SAMPLE_BITS - 1);

    state_t                 state_q, state_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_BITS-1:0] shreg_q, shreg_d;
    logic [SAMPLE_BITS-1:0] sample_q, sample_d;
    logic [SAMPLE_BITS:0]   shift_ext;
    logic [1:0]             miso_sync_q, miso_sync_d;
    logic                   ncs_q, ncs_d;
    logic                   sclk_q, sclk_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic                   cnt_clr, tick, phase_start;

    assign cnt_clr = (state_q == ST_IDLE);

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk        (sys_clk),
        .rst        (rst),
        .clr        (cnt_clr),
        .tick       (tick),
        .phase_start(phase_start)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        miso_sync_d = {miso_sync_q[0], MISO};
        shift_ext   = {shreg_q, miso_sync_q[1]};

        case (state_q)
            ST_IDLE: if (start) state_d = ST_LEAD;
            ST_LEAD: if (tick) state_d = ST_SHIFT;
            ST_SHIFT: begin
                // Capture one cycle after SCLK rises so a late slave edge still clears the synchronizer.
                if (sclk_q && phase_start) begin
                    shreg_d = shift_ext[SAMPLE_BITS-1:0];
                end
                if (tick && sclk_q) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = ST_TRAIL;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            ST_TRAIL: begin
                if (tick) begin
                    state_d  = ST_GAP;
                    sample_d = shreg_q;
                    valid_d  = 1'b1;
                end
            end
            ST_GAP:  if (tick) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ncs_d  = !(state_d inside {ST_LEAD, ST_SHIFT, ST_TRAIL});
        busy_d = (state_d != ST_IDLE);
        sclk_d = SCLK_IDLE;
        if (state_d == ST_SHIFT) begin
            sclk_d = (state_q != ST_SHIFT) ? 1'b0 : (tick ? !sclk_q : sclk_q);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            sample_q    <= '0;
            miso_sync_q <= 2'b00;
            ncs_q       <= 1'b1;
            sclk_q      <= SCLK_IDLE;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            sample_q    <= sample_d;
            miso_sync_q <= miso_sync_d;
            ncs_q       <= ncs_d;
            sclk_q      <= sclk_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
        end
    end

    assign nCS          = ncs_q;
    assign SCLK         = sclk_q;
    assign busy         = busy_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_spi_adc_master.sv
// Bench for spi_adc_master: three instances (default, D=3/N=16 with late slave, D=3/N=1)
// checked every cycle against a frame-timing model built from the cycle formulas.
module tb_spi_adc_master;

    localparam int NI = 3;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic [NI-1:0] start;
    logic [NI-1:0] miso;
    logic [NI-1:0] ncs_w, sclk_w, busy_w, vld_w;
    logic [15:0]   smp_a, smp_b;
    logic [0:0]    smp_c;

    always #5 sys_clk = ~sys_clk;

    spi_adc_master #(.CLK_DIV(5), .SAMPLE_BITS(16)) dut_a (
        .sys_clk(sys_clk), .rst(rst), .start(start[0]), .MISO(miso[0]),
        .nCS(ncs_w[0]), .SCLK(sclk_w[0]), .busy(busy_w[0]), .sample(smp_a), .sample_valid(vld_w[0]));
    spi_adc_master #(.CLK_DIV(3), .SAMPLE_BITS(16)) dut_b (
        .sys_clk(sys_clk), .rst(rst), .start(start[1]), .MISO(miso[1]),
        .nCS(ncs_w[1]), .SCLK(sclk_w[1]), .busy(busy_w[1]), .sample(smp_b), .sample_valid(vld_w[1]));
    spi_adc_master #(.CLK_DIV(3), .SAMPLE_BITS(1)) dut_c (
        .sys_clk(sys_clk), .rst(rst), .start(start[2]), .MISO(miso[2]),
        .nCS(ncs_w[2]), .SCLK(sclk_w[2]), .busy(busy_w[2]), .sample(smp_c), .sample_valid(vld_w[2]));

    int checks = 0;
    int failures = 0;
    int gcyc = 0;
    bit armed = 0;

    int          t0 [NI];
    logic [31:0] word [NI], frame_word [NI], exp_smp [NI], cur_word [NI];
    int          dly [NI], rises [NI], pend_cnt [NI];
    logic        pend_val [NI], p_ncs [NI], p_sclk [NI];
    int          vq [$];

    function automatic int dv(int i);
        return (i == 0) ? 5 : 3;
    endfunction

    function automatic int nb(int i);
        return (i == 2) ? 1 : 16;
    endfunction

    function automatic logic [31:0] mask(int i);
        return (32'd1 << nb(i)) - 32'd1;
    endfunction

    function automatic logic [31:0] get_smp(int i);
        case (i)
            0:       return {16'd0, smp_a};
            1:       return {16'd0, smp_b};
            default: return {31'd0, smp_c};
        endcase
    endfunction

    // Expected pin levels at cycle k of a frame (k=1 is the cycle after start is taken).
    function automatic logic e_ncs(int k, int d, int n);
        return !(k >= 1 && k <= (2*n+2)*d);
    endfunction
    function automatic logic e_busy(int k, int d, int n);
        return (k >= 1 && k <= (2*n+3)*d);
    endfunction
    function automatic logic e_vld(int k, int d, int n);
        return (k == (2*n+2)*d + 1);
    endfunction
    function automatic logic e_sclk(int k, int d, int n);
        return !(k >= d+1 && k <= (2*n+1)*d && ((k-d-1)/d) % 2 == 0);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s mismatch", tag);
        end
    endtask

    // Slave: MSB on nCS fall, next bit on each SCLK fall that follows a rising edge.
    task automatic slave_update();
        for (int i = 0; i < NI; i++) begin
            if (pend_cnt[i] > 0) begin
                pend_cnt[i]--;
                if (pend_cnt[i] == 0) miso[i] = pend_val[i];
            end
            if (p_ncs[i] === 1'b1 && ncs_w[i] === 1'b0) begin
                rises[i]    = 0;
                cur_word[i] = word[i];
                miso[i]     = cur_word[i][nb(i)-1];
            end else if (ncs_w[i] === 1'b0) begin
                if (p_sclk[i] === 1'b0 && sclk_w[i] === 1'b1) rises[i]++;
                if (p_sclk[i] === 1'b1 && sclk_w[i] === 1'b0 && rises[i] > 0 && rises[i] < nb(i)) begin
                    if (dly[i] == 0) begin
                        miso[i] = cur_word[i][nb(i)-1-rises[i]];
                    end else begin
                        pend_cnt[i] = dly[i];
                        pend_val[i] = cur_word[i][nb(i)-1-rises[i]];
                    end
                end
            end
            p_ncs[i]  = ncs_w[i];
            p_sclk[i] = sclk_w[i];
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            int d, n, k;
            d = dv(i);
            n = nb(i);
            k = (t0[i] < 0) ? 1000000 : gcyc - t0[i];
            if (e_vld(k, d, n)) exp_smp[i] = frame_word[i] & mask(i);
            chk($sformatf("nCS[%0d]@%0d", i, gcyc),    {31'd0, ncs_w[i]},  {31'd0, e_ncs(k, d, n)});
            chk($sformatf("SCLK[%0d]@%0d", i, gcyc),   {31'd0, sclk_w[i]}, {31'd0, e_sclk(k, d, n)});
            chk($sformatf("busy[%0d]@%0d", i, gcyc),   {31'd0, busy_w[i]}, {31'd0, e_busy(k, d, n)});
            chk($sformatf("valid[%0d]@%0d", i, gcyc),  {31'd0, vld_w[i]},  {31'd0, e_vld(k, d, n)});
            chk($sformatf("sample[%0d]@%0d", i, gcyc), get_smp(i),         exp_smp[i]);
        end
        if (vld_w[0] === 1'b1) vq.push_back(gcyc);
    endtask

    task automatic step();
        @(posedge sys_clk);
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                t0[i]      = -1;
                exp_smp[i] = 32'd0;
            end else if (start[i] && (t0[i] < 0 || gcyc - t0[i] >= (2*nb(i)+3)*dv(i) + 1)) begin
                t0[i]         = gcyc;
                frame_word[i] = word[i];
            end
        end
        if (rst) armed = 1;
        #1;
        slave_update();
        gcyc++;
        @(negedge sys_clk);
        if (armed) check_all();
    endtask

    initial begin
        rst   = 1'b1;
        start = '0;
        miso  = '0;
        for (int i = 0; i < NI; i++) begin
            t0[i] = -1; exp_smp[i] = 0; frame_word[i] = 0; cur_word[i] = 0;
            rises[i] = 0; pend_cnt[i] = 0; pend_val[i] = 0; p_ncs[i] = 1; p_sclk[i] = 1;
        end
        word[0] = 32'hA5C3; word[1] = 32'h5555; word[2] = 32'h1;
        dly[0] = 0; dly[1] = 1; dly[2] = 0;

        repeat (3) step();
        rst = 1'b0;
        step();

        // Single frame on all three instances (default, synchronizer margin, minimum corner).
        vq.delete();
        start = '1;
        step();
        start = '0;
        repeat (200) step();
        chk("single_frames", vq.size(), 1);

        // Back-to-back frames with start held high.
        vq.delete();
        word[0] = 32'h0001;
        start[0] = 1'b1;
        step();
        repeat (10) step();
        word[0] = 32'hFFFF;
        repeat (329) step();
        start[0] = 1'b0;
        repeat (200) step();
        chk("b2b_count", vq.size(), 2);
        if (vq.size() == 2) chk("b2b_spacing", vq[1] - vq[0], 176);

        // Start pulses at cycles 50 and 175 fall inside busy and are dropped.
        vq.delete();
        word[0] = 32'h3C96;
        start[0] = 1'b1; step(); start[0] = 1'b0;
        repeat (49) step();
        start[0] = 1'b1; step(); start[0] = 1'b0;
        repeat (124) step();
        start[0] = 1'b1; step(); start[0] = 1'b0;
        repeat (250) step();
        chk("ignored_frames", vq.size(), 1);

        // Start at cycle 176 is the first accepted one.
        vq.delete();
        start[0] = 1'b1; step(); start[0] = 1'b0;
        repeat (175) step();
        start[0] = 1'b1; step(); start[0] = 1'b0;
        repeat (200) step();
        chk("edge176_frames", vq.size(), 2);

        // Reset mid-frame at cycle 80, then a clean frame.
        vq.delete();
        word[0] = 32'h8E71;
        start = '1; step(); start = '0;
        repeat (79) step();
        rst = 1'b1; step(); rst = 1'b0;
        repeat (150) step();
        chk("rst_no_valid", vq.size(), 0);
        start = '1; step(); start = '0;
        repeat (200) step();
        chk("rst_recover_frames", vq.size(), 1);

        // Randomized starts, words and occasional resets.
        for (int s = 0; s < 1500; s++) begin
            for (int i = 0; i < NI; i++) begin
                word[i]  = $urandom & mask(i);
                start[i] = ($urandom_range(0, 7) == 0);
            end
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst   = 1'b0;
        start = '0;
        repeat (200) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
